// File: rtl/rv_isa_pkg.sv
// RV32 instruction-word views, format classes and major opcodes shared by the
// operand sequencer and its decoder.
package rv_isa_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [6:0] opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    reg_addr_t  rs2;
    reg_addr_t  rs1;
    logic [2:0] funct3;
    reg_addr_t  rd;
    opcode_t    opcode;
  } R_t;

  typedef struct packed {
    logic [11:0] imm;
    reg_addr_t   rs1;
    logic [2:0]  funct3;
    reg_addr_t   rd;
    opcode_t     opcode;
  } I_t;

  typedef struct packed {
    logic [19:0] imm;
    reg_addr_t   rd;
    opcode_t     opcode;
  } U_t;

  typedef union packed {
    R_t r;
    I_t i;
    U_t u;
  } instruction_t;

  typedef enum logic [1:0] {
    FMT_R       = 2'd0,
    FMT_I       = 2'd1,
    FMT_U       = 2'd2,
    FMT_ILLEGAL = 2'd3
  } fmt_t;

  localparam opcode_t OPC_OP     = 7'h33;
  localparam opcode_t OPC_OP_IMM = 7'h13;
  localparam opcode_t OPC_LOAD   = 7'h03;
  localparam opcode_t OPC_JALR   = 7'h67;
  localparam opcode_t OPC_LUI    = 7'h37;
  localparam opcode_t OPC_AUIPC  = 7'h17;

endpackage

// File: rtl/rv_format_decode.sv
// Combinational opcode classifier and immediate sign-extender; the immediate
// is zero for formats that carry none.
module rv_format_decode
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  instruction_t    instr,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    fmt = FMT_ILLEGAL;
    imm = '0;
    case (instr.r.opcode)
      OPC_OP: fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr.i.imm));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr.u.imm, 12'b0}));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_operand_sequencer.sv
// Accepts one instruction, reads its source registers through a single shared
// 1-cycle-latency RF port, and presents the assembled micro-op downstream.
module rv_operand_sequencer
  import rv_isa_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  instruction_t    in_instr,
  output logic            rf_req,
  output reg_addr_t       rf_addr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output instruction_t    out_instr,
  output fmt_t            out_fmt,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_imm
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t          state_q, state_d, prev_state_q;
  instruction_t    instr_q;
  fmt_t            fmt_q, dec_fmt;
  logic [XLEN-1:0] imm_q, dec_imm, op_a_q, op_b_q;
  logic            need_b_q, need_a_d, need_b_d, accept;

  rv_format_decode #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  // x0 reads are skipped entirely when SKIP_X0 is set; the operand stays 0.
  assign need_a_d = (dec_fmt == FMT_R || dec_fmt == FMT_I) &&
                    (!SKIP_X0 || in_instr.r.rs1 != '0);
  assign need_b_d = (dec_fmt == FMT_R) && (!SKIP_X0 || in_instr.r.rs2 != '0);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    rf_req    = 1'b0;
    rf_addr   = '0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) begin
          if (need_a_d)      state_d = S_RD_A;
          else if (need_b_d) state_d = S_RD_B;
          else               state_d = S_OUT;
        end
      end
      S_RD_A: begin
        rf_req  = 1'b1;
        rf_addr = instr_q.r.rs1;
        state_d = need_b_q ? S_RD_B : S_CAP;
      end
      S_RD_B: begin
        rf_req  = 1'b1;
        rf_addr = instr_q.r.rs2;
        state_d = S_CAP;
      end
      S_CAP: state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too, since they drive outputs that
      // must read 0 straight out of reset.
      state_q      <= S_IDLE;
      prev_state_q <= S_IDLE;
      instr_q      <= '0;
      fmt_q        <= FMT_R;
      imm_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      need_b_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= state_q;
      case (state_q)
        S_IDLE: if (accept) begin
          instr_q  <= in_instr;
          fmt_q    <= dec_fmt;
          imm_q    <= dec_imm;
          op_a_q   <= '0;
          op_b_q   <= '0;
          need_b_q <= need_b_d;
        end
        // The rs1 datum lands while rs2 is being requested.
        S_RD_B: if (prev_state_q == S_RD_A) op_a_q <= rf_rdata;
        S_CAP: begin
          if (prev_state_q == S_RD_B) op_b_q <= rf_rdata;
          else                        op_a_q <= rf_rdata;
        end
        default: ;
      endcase
    end
  end

  assign out_instr = instr_q;
  assign out_fmt   = fmt_q;
  assign out_op_a  = op_a_q;
  assign out_op_b  = op_b_q;
  assign out_imm   = imm_q;

endmodule

// File: tb/tb_rv_operand_sequencer.sv
// Directed bench for rv_operand_sequencer: drives and samples on the falling
// edge, with a small behavioural register file answering read strobes.
module tb_rv_operand_sequencer;
  import rv_isa_pkg::*;

  localparam logic [31:0] LUI_T4  = 32'h0AA01EB7;
  localparam logic [31:0] ADD_3   = 32'h002081B3;
  localparam logic [31:0] ADDI_M1 = 32'hFFF00293;
  localparam logic [31:0] ADDI_X1 = 32'h00508313;
  localparam logic [31:0] ADD_X0  = 32'h002003B3;
  localparam logic [31:0] LUI_X4  = 32'h12345237;
  localparam logic [31:0] ILLEGAL = 32'h0000007F;

  logic         clk, rst, in_valid, in_ready, rf_req, out_valid, out_ready;
  instruction_t in_instr, out_instr;
  reg_addr_t    rf_addr;
  logic [31:0]  rf_rdata, out_op_a, out_op_b, out_imm;
  fmt_t         out_fmt;
  logic [31:0]  rf_model [32];
  int           vectors = 0;
  int           miscompares = 0;

  rv_operand_sequencer #(.XLEN(32), .SKIP_X0(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .rf_req    (rf_req),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_fmt   (out_fmt),
    .out_op_a  (out_op_a),
    .out_op_b  (out_op_b),
    .out_imm   (out_imm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file with one-cycle read latency; idle cycles return a marker
  // value so a capture on the wrong cycle is visible.
  always @(posedge clk) rf_rdata <= rf_req ? rf_model[rf_addr] : 32'hBAD0_0BAD;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_uop(input string t, input fmt_t f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm);
    check({t, "_valid"}, 32'(out_valid), 32'd1);
    check({t, "_fmt"},   32'(out_fmt),   32'(f));
    check({t, "_op_a"},  out_op_a,       a);
    check({t, "_op_b"},  out_op_b,       b);
    check({t, "_imm"},   out_imm,        imm);
  endtask

  // Offers one word in the current cycle (T); returns in cycle T+1.
  task automatic offer(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    #1;
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_instr = '0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'hA000_0000 | i;
    rf_model[1] = 32'h11;
    rf_model[2] = 32'h22;

    // Reset state
    tick(); tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rf_req",    32'(rf_req),    32'd0);
    check("rst_op_a",      out_op_a,       32'd0);
    check("rst_imm",       out_imm,        32'd0);
    check("rst_instr",     out_instr,      32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Case 1: lui, no reads, valid at T+1
    offer(LUI_T4);
    check("lui_rf_req", 32'(rf_req), 32'd0);
    check("lui_in_ready", 32'(in_ready), 32'd0);
    check("lui_rd", 32'(out_instr.u.rd), 32'd29);
    check_uop("lui", FMT_U, 32'd0, 32'd0, 32'h0AA01000);
    tick();
    check("lui_done_valid", 32'(out_valid), 32'd0);
    check("lui_done_ready", 32'(in_ready), 32'd1);

    // Case 2: add x3,x1,x2, reads at T+1/T+2, valid at T+4
    offer(ADD_3);
    check("add_t1_req",  32'(rf_req),  32'd1);
    check("add_t1_addr", 32'(rf_addr), 32'd1);
    tick();
    check("add_t2_req",  32'(rf_req),  32'd1);
    check("add_t2_addr", 32'(rf_addr), 32'd2);
    tick();
    check("add_t3_req",   32'(rf_req),    32'd0);
    check("add_t3_valid", 32'(out_valid), 32'd0);
    tick();
    check_uop("add", FMT_R, 32'h11, 32'h22, 32'd0);
    check("add_instr", out_instr, ADD_3);
    tick();
    check("add_done_valid", 32'(out_valid), 32'd0);

    // Case 3: addi x5,x0,-1, x0 skipped
    offer(ADDI_M1);
    check("addi0_rf_req", 32'(rf_req), 32'd0);
    check_uop("addi0", FMT_I, 32'd0, 32'd0, 32'hFFFFFFFF);
    tick();

    // I-format with one real read: valid at T+3
    offer(ADDI_X1);
    check("addi1_req",  32'(rf_req),  32'd1);
    check("addi1_addr", 32'(rf_addr), 32'd1);
    tick();
    check("addi1_cap_req", 32'(rf_req), 32'd0);
    check("addi1_cap_valid", 32'(out_valid), 32'd0);
    tick();
    check_uop("addi1", FMT_I, 32'h11, 32'd0, 32'd5);
    tick();

    // R-format with rs1=x0: only rs2 read, lands in op_b
    offer(ADD_X0);
    check("addx0_req",  32'(rf_req),  32'd1);
    check("addx0_addr", 32'(rf_addr), 32'd2);
    tick(); tick();
    check_uop("addx0", FMT_R, 32'd0, 32'h22, 32'd0);
    tick();

    // Case 4: back-pressure for 5 cycles with a second word waiting
    out_ready = 1'b0;
    offer(ADD_3);
    tick(); tick(); tick();
    in_valid = 1'b1;
    in_instr = LUI_X4;
    for (int k = 0; k < 5; k++) begin
      check_uop("hold", FMT_R, 32'h11, 32'h22, 32'd0);
      check("hold_instr",    out_instr,       ADD_3);
      check("hold_in_ready", 32'(in_ready),   32'd0);
      check("hold_rf_req",   32'(rf_req),     32'd0);
      tick();
    end
    out_ready = 1'b1;
    check_uop("release", FMT_R, 32'h11, 32'h22, 32'd0);
    tick();
    check("after_accept_valid", 32'(out_valid), 32'd0);
    check("after_accept_ready", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    in_instr = '0;
    check_uop("second", FMT_U, 32'd0, 32'd0, 32'h12345000);
    check("second_instr", out_instr, LUI_X4);
    tick();

    // Case 5: reset pulsed during RD_B
    offer(ADD_3);
    tick();
    check("rst5_rdb_req",  32'(rf_req),  32'd1);
    check("rst5_rdb_addr", 32'(rf_addr), 32'd2);
    rst = 1'b1;
    tick();
    check("rst5_valid",    32'(out_valid), 32'd0);
    check("rst5_req",      32'(rf_req),    32'd0);
    check("rst5_op_a",     out_op_a,       32'd0);
    check("rst5_imm",      out_imm,        32'd0);
    check("rst5_fmt",      32'(out_fmt),   32'd0);
    check("rst5_instr",    out_instr,      32'd0);
    check("rst5_in_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("rst5_ready_after", 32'(in_ready), 32'd1);
    tick();
    check("rst5_late_data", out_op_a, 32'd0);
    check("rst5_idle_valid", 32'(out_valid), 32'd0);
    offer(LUI_T4);
    check("rst5_lui_req", 32'(rf_req), 32'd0);
    check_uop("rst5_lui", FMT_U, 32'd0, 32'd0, 32'h0AA01000);
    tick();

    // Case 6: illegal opcode
    offer(ILLEGAL);
    check("ill_req", 32'(rf_req), 32'd0);
    check_uop("ill", FMT_ILLEGAL, 32'd0, 32'd0, 32'd0);
    tick();
    check("ill_done_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
